// File: rtl/fft32_mdc_ctrl.sv
// fft32_mdc_ctrl: frame sequencer for a 32-point MDC FFT pipeline.
// There are 4 lanes and 8 beats per frame. The block accepts input beats,
// inserts zero beats when a frame stalls, and tags each issued beat. The tag
// is {valid, beat index, bad}. Tags travel along a DOUT-deep delay line.
// Twiddle ROM starts, commutator selects and output framing are taken from
// the depth of the delay line that matches each datapath stage.
module fft32_mdc_ctrl #(
    parameter int D0   = 2,   // acceptance -> stage-0 twiddle multiply
    parameter int D1   = 6,   // acceptance -> stage-1 twiddle multiply
    parameter int DOUT = 10   // acceptance -> pipeline output
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_sop,
    output logic in_ready,
    output logic pad,
    output logic st0_start,
    output logic st1_start,
    output logic sw0,
    output logic sw1,
    output logic out_valid,
    output logic out_sop,
    output logic out_eop,
    output logic out_err,
    output logic err,
    input  logic clr_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
        logic       bad;
    } beat_t;

    // A registered strobe that fires at depth d is computed from depth d-1.
    // For D0 == 1, stage-0 START has to fire in the acceptance cycle. In that
    // case it is taken straight from the issue slot.
    localparam int ST0_TAP = (D0 >= 2) ? D0 - 2 : 0;
    localparam int ST1_TAP = D1 - 2;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;      // index of the next beat to issue
    logic       err_q, err_d;
    beat_t      issue_s;
    logic       new_err_s;

    beat_t      tap_s [DOUT];      // tap_s[k] = entry at depth k
    beat_t      dl_q  [1:DOUT-1];
    beat_t      dl_d  [1:DOUT-1];

    logic st0_start_q, st0_start_d;
    logic st1_start_q, st1_start_d;
    logic sw0_q, sw0_d;
    logic sw1_q, sw1_d;
    logic out_valid_q, out_valid_d;
    logic out_sop_q, out_sop_d;
    logic out_eop_q, out_eop_d;
    logic out_err_q, out_err_d;

    // Frame FSM: next state, beat index, issue slot, in_ready/pad, new errors.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        issue_s   = '0;
        new_err_s = 1'b0;
        in_ready  = 1'b0;
        pad       = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                // A beat that is not SOP is dropped without comment.
                if (in_valid && in_sop) begin
                    issue_s.vld = 1'b1;
                    issue_s.idx = 3'd0;
                    idx_d       = 3'd1;
                    state_d     = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                in_ready    = 1'b1;
                issue_s.vld = 1'b1;
                issue_s.idx = idx_q;
                idx_d       = idx_q + 3'd1;
                if (in_valid) begin
                    // An SOP in the middle of a frame is kept as a data beat.
                    new_err_s = in_sop;
                    state_d   = (idx_q == 3'd7) ? S_IDLE : S_LOAD;
                end else begin
                    // The frame stalled: this slot is already a zero beat.
                    pad         = 1'b1;
                    issue_s.bad = 1'b1;
                    new_err_s   = 1'b1;
                    state_d     = (idx_q == 3'd7) ? S_IDLE : S_PAD;
                end
            end
            S_PAD: begin
                pad         = 1'b1;
                issue_s.vld = 1'b1;
                issue_s.idx = idx_q;
                issue_s.bad = 1'b1;
                idx_d       = idx_q + 3'd1;
                state_d     = (idx_q == 3'd7) ? S_IDLE : S_PAD;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Sticky error: a new error has priority over a clear in the same cycle.
    always_comb begin
        if (new_err_s) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Delay line taps: depth 0 is the issue slot, and deeper taps are registers.
    always_comb begin
        tap_s[0] = issue_s;
        for (int k = 1; k < DOUT; k++) begin
            tap_s[k] = dl_q[k];
            dl_d[k]  = tap_s[k-1];
        end
    end

    // Strobe and framing outputs, computed one depth early so they can be registered.
    always_comb begin
        st0_start_d = tap_s[ST0_TAP].vld && (tap_s[ST0_TAP].idx == 3'd0);
        st1_start_d = tap_s[ST1_TAP].vld && (tap_s[ST1_TAP].idx == 3'd0);
        sw0_d       = tap_s[D0-1].vld && tap_s[D0-1].idx[2];
        sw1_d       = tap_s[D1-1].vld && tap_s[D1-1].idx[0];
        out_valid_d = tap_s[DOUT-1].vld;
        out_sop_d   = tap_s[DOUT-1].vld && (tap_s[DOUT-1].idx == 3'd0);
        out_eop_d   = tap_s[DOUT-1].vld && (tap_s[DOUT-1].idx == 3'd7);
        out_err_d   = tap_s[DOUT-1].vld && (tap_s[DOUT-1].idx == 3'd7)
                      && tap_s[DOUT-1].bad;
    end

    // State, index, error and delay-line registers; reset drops all beats in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            err_q   <= 1'b0;
            for (int k = 1; k < DOUT; k++) begin
                dl_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            for (int k = 1; k < DOUT; k++) begin
                dl_q[k] <= dl_d[k];
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st0_start_q <= 1'b0;
            st1_start_q <= 1'b0;
            sw0_q       <= 1'b0;
            sw1_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            st0_start_q <= st0_start_d;
            st1_start_q <= st1_start_d;
            sw0_q       <= sw0_d;
            sw1_q       <= sw1_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_err_q   <= out_err_d;
        end
    end

    assign st0_start = (D0 >= 2) ? st0_start_q : st0_start_d;
    assign st1_start = st1_start_q;
    assign sw0       = sw0_q;
    assign sw1       = sw1_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_err   = out_err_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fft32_mdc_ctrl.sv
// Directed bench for fft32_mdc_ctrl.
// Instance a uses the default delays (2/6/10).
// Instance b uses delays 1/3/4.
// Both instances get the same stimulus.
// Cycle c is the interval that ends at the c-th rising edge after stimulus
// starts. Outputs are sampled 1 ns after the falling edge.
module tb_fft32_mdc_ctrl;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_sop, clr_err;
    logic a_rdy, a_pad, a_st0, a_st1, a_sw0, a_sw1, a_ov, a_sop, a_eop, a_oerr, a_err;
    logic b_rdy, b_pad, b_st0, b_st1, b_sw0, b_sw1, b_ov, b_sop, b_eop, b_oerr, b_err;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fft32_mdc_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .in_ready(a_rdy), .pad(a_pad), .st0_start(a_st0), .st1_start(a_st1),
        .sw0(a_sw0), .sw1(a_sw1), .out_valid(a_ov), .out_sop(a_sop),
        .out_eop(a_eop), .out_err(a_oerr), .err(a_err), .clr_err(clr_err)
    );

    fft32_mdc_ctrl #(.D0(1), .D1(3), .DOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .in_ready(b_rdy), .pad(b_pad), .st0_start(b_st0), .st1_start(b_st1),
        .sw0(b_sw0), .sw1(b_sw1), .out_valid(b_ov), .out_sop(b_sop),
        .out_eop(b_eop), .out_err(b_oerr), .err(b_err), .clr_err(clr_err)
    );

    task automatic chk(input string tag, input int c, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s@%0d observed=%b expected=%b", tag, c, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic clr);
        @(negedge clk);
        in_valid = v;
        in_sop   = s;
        clr_err  = clr;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        clr_err  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        // Reset state.
        chk("rst_rdy", 0, a_rdy, 1'b1);
        chk("rst_pad", 0, a_pad, 1'b0);
        chk("rst_st0", 0, a_st0, 1'b0);
        chk("rst_ov",  0, a_ov,  1'b0);
        chk("rst_err", 0, a_err, 1'b0);
        chk("rst_b_rdy", 0, b_rdy, 1'b1);
        chk("rst_b_st0", 0, b_st0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, plus the parameter sweep on instance b.
        for (int c = 0; c < 20; c++) begin
            drive(c <= 7, c == 0, 1'b0);
            chk("sf_rdy",  c, a_rdy, 1'b1);
            chk("sf_pad",  c, a_pad, 1'b0);
            chk("sf_st0",  c, a_st0, c == 1);
            chk("sf_st1",  c, a_st1, c == 5);
            chk("sf_sw0",  c, a_sw0, (c >= 6) && (c <= 9));
            chk("sf_sw1",  c, a_sw1, (c >= 6) && (c <= 13) && (((c - 6) % 2) == 1));
            chk("sf_ov",   c, a_ov,  (c >= 10) && (c <= 17));
            chk("sf_sop",  c, a_sop, c == 10);
            chk("sf_eop",  c, a_eop, c == 17);
            chk("sf_oerr", c, a_oerr, 1'b0);
            chk("sf_err",  c, a_err, 1'b0);
            chk("pw_st0",  c, b_st0, c == 0);
            chk("pw_st1",  c, b_st1, c == 2);
            chk("pw_ov",   c, b_ov,  (c >= 4) && (c <= 11));
            chk("pw_sop",  c, b_sop, c == 4);
            chk("pw_eop",  c, b_eop, c == 11);
        end

        // Two frames back to back.
        for (int c = 0; c < 28; c++) begin
            drive(c <= 15, (c == 0) || (c == 8), 1'b0);
            chk("bb_rdy", c, a_rdy, 1'b1);
            chk("bb_st0", c, a_st0, (c == 1) || (c == 9));
            chk("bb_st1", c, a_st1, (c == 5) || (c == 13));
            chk("bb_ov",  c, a_ov,  (c >= 10) && (c <= 25));
            chk("bb_sop", c, a_sop, (c == 10) || (c == 18));
            chk("bb_eop", c, a_eop, (c == 17) || (c == 25));
            chk("bb_err", c, a_err, 1'b0);
        end

        // Gap in the middle of a frame: in_valid drops in cycle 3, which is padded.
        for (int c = 0; c < 20; c++) begin
            drive((c <= 7) && (c != 3), c == 0, 1'b0);
            chk("gp_rdy",  c, a_rdy, !((c >= 4) && (c <= 7)));
            chk("gp_pad",  c, a_pad, (c >= 3) && (c <= 7));
            chk("gp_err",  c, a_err, c >= 4);
            chk("gp_ov",   c, a_ov,  (c >= 10) && (c <= 17));
            chk("gp_eop",  c, a_eop, c == 17);
            chk("gp_oerr", c, a_oerr, c == 17);
        end
        drive(1'b0, 1'b0, 1'b1);
        chk("clr_same", 0, a_err, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("clr_next", 1, a_err, 1'b0);

        // Stray beats without SOP while idle.
        for (int c = 0; c < 14; c++) begin
            drive(c <= 2, 1'b0, 1'b0);
            chk("st_ov",  c, a_ov,  1'b0);
            chk("st_err", c, a_err, 1'b0);
            chk("st_pad", c, a_pad, 1'b0);
        end

        // SOP on beat 4, together with clr_err, so the new error wins.
        for (int c = 0; c < 20; c++) begin
            drive(c <= 7, (c == 0) || (c == 4), c == 4);
            chk("s4_err",  c, a_err, c >= 5);
            chk("s4_ov",   c, a_ov,  (c >= 10) && (c <= 17));
            chk("s4_sop",  c, a_sop, c == 10);
            chk("s4_eop",  c, a_eop, c == 17);
            chk("s4_oerr", c, a_oerr, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("s4_clr", 0, a_err, 1'b0);

        // Reset in the middle of a frame, asserted during cycle 5.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, c == 0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk("rm_rdy", 5, a_rdy, 1'b1);
        chk("rm_pad", 5, a_pad, 1'b0);
        chk("rm_st0", 5, a_st0, 1'b0);
        chk("rm_sw0", 5, a_sw0, 1'b0);
        chk("rm_ov",  5, a_ov,  1'b0);
        chk("rm_err", 5, a_err, 1'b0);
        chk("rm_b_ov", 5, b_ov, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 6; c < 22; c++) begin
            drive(1'b0, 1'b0, 1'b0);
            chk("rm_ov_after", c, a_ov, 1'b0);
            chk("rm_st1_after", c, a_st1, 1'b0);
            chk("rm_b_ov_after", c, b_ov, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
